word_fifo_axi_writer: RTL and testbench

- Downstream neighbour of the byte packer and its word FIFO.
- Drains 256-bit packed words from the word FIFO and writes them to DDR as fixed-length AXI4 INCR write bursts.
- Uses a linear address pointer that wraps inside a circular region.
- Reports burst completion count, busy, and sticky write-error status to the control/debug logic.

---
 rtl/word_fifo_axi_writer.sv | 133 +++++++++++++
 tb/tb_word_fifo_axi_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_fifo_axi_writer.sv
// Drains packed words from a first-word-fall-through FIFO into fixed-length AXI4 INCR write bursts,
// walking a circular DDR region one burst at a time with a single outstanding transaction.
module word_fifo_axi_writer #(
   parameter int                    DATA_WIDTH  = 256,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    BURST_LEN   = 8,
   parameter int                    COUNT_WIDTH = 6,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter logic [ADDR_WIDTH-1:0] REGION_SIZE = ADDR_WIDTH'(32'h0010_0000)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [DATA_WIDTH-1:0]   fifo_dout,
   input  logic                    fifo_empty,
   input  logic [COUNT_WIDTH-1:0]  fifo_count,
   output logic                    fifo_rd_en,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic                    busy,
   output logic                    wr_error,
   output logic [31:0]             burst_count,
   output logic [1:0]              o_dbg_state
);

   // Handshake rule on every channel: a transfer happens on the rising edge where valid and
   // ready are both high; valid never waits on ready and the payload holds while valid is unanswered.

   localparam int                    BEAT_W         = 5;
   localparam logic [ADDR_WIDTH-1:0] LP_BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] LP_REGION_END  = BASE_ADDR + REGION_SIZE;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr_ptr;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [BEAT_W-1:0]     r_beat_cnt;
   logic                  r_awvalid;
   logic                  r_bready;
   logic                  r_busy;
   logic                  r_wr_error;
   logic [31:0]           r_burst_count;

   logic                  w_in_data;
   logic                  w_wvalid;
   logic                  w_wlast;
   logic                  w_beat_acc;
   logic                  w_start;
   logic [ADDR_WIDTH-1:0] w_ptr_inc;

   assign w_in_data  = (r_state == S_DATA);
   assign w_wvalid   = w_in_data && !fifo_empty;
   assign w_wlast    = w_in_data && (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
   assign w_beat_acc = w_wvalid && m_axi_wready;
   // Only whole bursts are started, so the FIFO must already hold every beat.
   assign w_start    = enable && (32'(fifo_count) >= BURST_LEN);
   assign w_ptr_inc  = r_addr_ptr + LP_BURST_BYTES;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_addr_ptr    <= BASE_ADDR;
         r_awaddr      <= BASE_ADDR;
         r_beat_cnt    <= '0;
         r_awvalid     <= 1'b0;
         r_bready      <= 1'b0;
         r_busy        <= 1'b0;
         r_wr_error    <= 1'b0;
         r_burst_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) begin
               r_state   <= S_ADDR;
               r_awaddr  <= r_addr_ptr;
               r_awvalid <= 1'b1;
               r_busy    <= 1'b1;
            end
            S_ADDR: if (r_awvalid && m_axi_awready) begin
               r_state    <= S_DATA;
               r_awvalid  <= 1'b0;
               r_beat_cnt <= '0;
            end
            S_DATA: if (w_beat_acc) begin
               r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
               if (w_wlast) begin
                  r_state  <= S_RESP;
                  r_bready <= 1'b1;
               end
            end
            S_RESP: if (m_axi_bvalid) begin
               r_state       <= S_IDLE;
               r_bready      <= 1'b0;
               r_busy        <= 1'b0;
               r_burst_count <= r_burst_count + 32'd1;
               r_wr_error    <= r_wr_error || (m_axi_bresp != 2'b00);
               // Wrap to the region start when the pointer reaches the region end.
               r_addr_ptr    <= (w_ptr_inc == LP_REGION_END) ? BASE_ADDR : w_ptr_inc;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign fifo_rd_en    = w_beat_acc;
   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awlen   = 8'(BURST_LEN - 1);
   assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
   assign m_axi_awburst = 2'b01;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = fifo_dout;
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = w_wlast;
   assign m_axi_wvalid  = w_wvalid;
   assign m_axi_bready  = r_bready;
   assign busy          = r_busy;
   assign wr_error      = r_wr_error;
   assign burst_count   = r_burst_count;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_word_fifo_axi_writer.sv
// Bench for word_fifo_axi_writer: a queue-backed FIFO and a delay-programmable AXI slave,
// checked against a word-stream / burst-arithmetic reference model.
module tb_word_fifo_axi_writer;

   localparam int          DW     = 256;
   localparam int          AW     = 32;
   localparam int          BL     = 8;
   localparam int          CW     = 6;
   localparam logic [31:0] BASE   = 32'h0;
   localparam logic [31:0] REGION = 32'h200;
   localparam logic [31:0] BB     = BL * DW / 8;

   logic          clk = 1'b0;
   logic          rst, enable;
   logic [DW-1:0] fifo_dout;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          fifo_rd_en;
   logic [AW-1:0] awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic          awvalid, awready;
   logic [DW-1:0] wdata;
   logic [DW/8-1:0] wstrb;
   logic          wlast, wvalid, wready;
   logic [1:0]    bresp;
   logic          bvalid, bready;
   logic          busy, wr_error;
   logic [31:0]   burst_count;
   logic [1:0]    dbg_state;

   word_fifo_axi_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .COUNT_WIDTH(CW),
                          .BASE_ADDR(BASE), .REGION_SIZE(REGION)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en),
      .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
      .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .busy(busy), .wr_error(wr_error), .burst_count(burst_count), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] push_q[$];
   logic [DW-1:0] exp_q[$];

   int   n_vec = 0, n_err = 0;
   int   aw_idx = 0, beat_idx = 0, b_idx = 0, pops = 0, b_owed = 0;
   int   aw_wait = 0, w_wait = 0, b_wait = 0, max_delay = 0, err_b_idx = -1;
   logic err_model = 1'b0, pend_pop = 1'b0, force_cnt = 1'b0;
   logic prev_aw_stall = 1'b0, prev_w_stall = 1'b0;
   logic [AW-1:0] prev_awaddr;
   logic [DW-1:0] prev_wdata;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic push(input logic [DW-1:0] w);
      push_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic drive_fifo();
      fifo_empty = (fifo_q.size() == 0);
      fifo_dout  = fifo_empty ? '0 : fifo_q[0];
      fifo_count = force_cnt ? CW'(BL) : CW'(fifo_q.size());
   endtask

   // One clock: apply effects of the edge just taken, drive new inputs, then record the
   // handshakes that the next edge will complete.
   task automatic step();
      logic [DW-1:0] e;
      @(posedge clk); #1;
      if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pend_pop = 1'b0;
      while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
      drive_fifo();
      awready = (aw_wait == 0);
      wready  = (w_wait == 0);
      bvalid  = (b_owed > 0) && (b_wait == 0);
      bresp   = (bvalid && b_idx == err_b_idx) ? 2'b10 : 2'b00;
      #1;
      if (!rst) begin
         if (prev_aw_stall) begin
            chk("aw_hold_valid", awvalid, 1);
            chk("aw_hold_addr", awaddr, prev_awaddr);
         end
         if (prev_w_stall) begin
            chk("w_hold_valid", wvalid, 1);
            chk("w_hold_data", wdata, prev_wdata);
         end
         if (awvalid && awready) begin
            chk("awaddr", awaddr, BASE + (aw_idx * BB) % REGION);
            chk("awlen", awlen, BL - 1);
            chk("awsize", awsize, 5);
            chk("awburst", awburst, 1);
            chk("aw_outstanding", aw_idx, b_idx);
            aw_idx++;
            aw_wait = $urandom_range(0, max_delay);
         end else if (awvalid && aw_wait > 0) aw_wait--;
         if (wvalid && wready) begin
            chk("aw_before_w", (beat_idx / BL) < aw_idx, 1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk("wdata", wdata, e);
            chk("wlast", wlast, (beat_idx % BL) == BL - 1);
            chk("wstrb", wstrb, {(DW/8){1'b1}});
            chk("rd_en_beat", fifo_rd_en, 1);
            if ((beat_idx % BL) == BL - 1) b_owed++;
            beat_idx++;
            w_wait = $urandom_range(0, max_delay);
         end else begin
            chk("rd_en_idle", fifo_rd_en, 0);
            if (wvalid && w_wait > 0) w_wait--;
         end
         if (fifo_rd_en) begin
            pend_pop = 1'b1;
            pops++;
         end
         if (bvalid && bready) begin
            err_model = err_model || (bresp != 2'b00);
            b_idx++;
            b_owed--;
            b_wait = $urandom_range(0, max_delay);
         end else if (b_owed > 0 && b_wait > 0) b_wait--;
         prev_aw_stall = awvalid && !awready;
         prev_awaddr   = awaddr;
         prev_w_stall  = wvalid && !wready;
         prev_wdata    = wdata;
      end
   endtask

   task automatic wait_bursts(input int target, input int budget);
      int c = 0;
      while (b_idx < target && c < budget) begin
         step();
         c++;
      end
      chk("burst_timeout", b_idx, target);
      step();
      step();
      chk("burst_count", burst_count, b_idx);
      chk("wr_error", wr_error, err_model);
   endtask

   initial begin
      int a0, p0, b0, c, pushed;
      logic seen;
      rst = 1'b1; enable = 1'b0;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
      drive_fifo();

      // Reset
      step(); step();
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_wlast", wlast, 0);
      chk("rst_bready", bready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_error", wr_error, 0);
      chk("rst_burst_count", burst_count, 0);
      chk("rst_awaddr", awaddr, BASE);
      chk("rst_state", dbg_state, 0);
      rst = 1'b0;

      // Single burst of 1..8, zero-wait slave
      for (int i = 1; i <= 8; i++) push(DW'(i));
      enable = 1'b1;
      wait_bursts(1, 100);
      chk("single_aw", aw_idx, 1);
      chk("single_beats", beat_idx, 8);
      chk("single_pops", pops, 8);
      chk("single_busy", busy, 0);

      // Threshold: seven words never start a burst
      for (int i = 0; i < 7; i++) push(rand_word());
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (awvalid) seen = 1'b1;
      end
      chk("thresh_no_aw", seen, 0);
      push(rand_word());
      step(); step();
      chk("thresh_aw", awvalid, 1);
      wait_bursts(2, 100);

      // Mid-burst underflow only stalls
      force_cnt = 1'b1;
      b0 = beat_idx; p0 = pops;
      for (int i = 0; i < 3; i++) push(rand_word());
      c = 0;
      while (!awvalid && c < 20) begin step(); c++; end
      force_cnt = 1'b0;
      for (int i = 0; i < 12; i++) step();
      chk("stall_beats", beat_idx - b0, 3);
      chk("stall_pops", pops - p0, 3);
      chk("stall_wvalid", wvalid, 0);
      chk("stall_busy", busy, 1);
      for (int i = 0; i < 5; i++) push(rand_word());
      wait_bursts(3, 100);

      // Random back-pressure over 20 bursts
      max_delay = 5;
      b0 = b_idx; p0 = pops; pushed = 0; c = 0;
      while (b_idx < b0 + 20 && c < 20000) begin
         if (pushed < 20 * BL && fifo_q.size() + push_q.size() < 40 && $urandom_range(0, 1) == 1) begin
            push(rand_word());
            pushed++;
         end
         step();
         c++;
      end
      wait_bursts(b0 + 20, 100);
      chk("bp_pops", pops - p0, 160);
      chk("bp_exp_drained", exp_q.size(), 0);
      max_delay = 0;

      // Wrap through the 0x200 region over five bursts
      a0 = aw_idx;
      for (int i = 0; i < 5 * BL; i++) push(rand_word());
      wait_bursts(b_idx + 5, 200);
      chk("wrap_aw", aw_idx - a0, 5);
      chk("wrap_ptr_awaddr", awaddr, BASE + ((aw_idx - 1) * BB) % REGION);

      // Error response on the second burst of four
      b0 = b_idx;
      err_b_idx = b0 + 1;
      for (int i = 0; i < 4 * BL; i++) push(rand_word());
      wait_bursts(b0 + 1, 100);
      chk("err_before", wr_error, 0);
      wait_bursts(b0 + 2, 100);
      chk("err_set", wr_error, 1);
      wait_bursts(b0 + 4, 200);
      chk("err_sticky", wr_error, 1);
      chk("err_count", burst_count, b0 + 4);

      // Enable dropped mid-burst: that burst completes, nothing follows
      a0 = aw_idx; b0 = b_idx;
      for (int i = 0; i < 2 * BL; i++) push(rand_word());
      c = 0;
      while (!awvalid && c < 20) begin step(); c++; end
      enable = 1'b0;
      wait_bursts(b0 + 1, 100);
      for (int i = 0; i < 30; i++) step();
      chk("en_off_aw", aw_idx - a0, 1);
      chk("en_off_busy", busy, 0);
      chk("en_off_left", fifo_q.size(), BL);
      chk("total_pops", pops, beat_idx);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
